// File: rtl/seq_alu_pkg.sv
// Shared opcode constants, decoded-operation and FSM state types, and the instruction decoder.
// The M-extension operations decode as legal only when SEQ_ALU_MULDIV_EN is defined.
package seq_alu_pkg;

    localparam logic [6:0] ITYPE   = 7'b0010011;
    localparam logic [6:0] RTYPE   = 7'b0110011;
    localparam logic [6:0] BTYPE   = 7'b1100011;
    localparam logic [6:0] LTYPE   = 7'b0000011;
    localparam logic [6:0] STYPE   = 7'b0100011;
    localparam logic [6:0] J_ITYPE = 7'b1100111;

    localparam logic [6:0] FUNC7_BASE = 7'b0000000;
    localparam logic [6:0] FUNC7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNC7_MEXT = 7'b0000001;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_ILLEGAL
    } alu_op_e;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_e;

    function automatic alu_op_e decode_op(input logic [6:0] opcode, input logic [2:0] func3,
                                          input logic [6:0] func7);
        alu_op_e op;
        logic    base_ok;
        op = OP_ILLEGAL;
        // Immediate forms carry immediate bits in func7, so only shifts constrain it there.
        base_ok = (opcode == ITYPE) || (func7 == FUNC7_BASE);
        case (opcode)
            ITYPE, RTYPE: begin
                if (opcode == RTYPE && func7 == FUNC7_MEXT) begin
`ifdef SEQ_ALU_MULDIV_EN
                    case (func3)
                        3'b000:  op = OP_MUL;
                        3'b001:  op = OP_MULH;
                        3'b010:  op = OP_MULHSU;
                        3'b011:  op = OP_MULHU;
                        3'b100:  op = OP_DIV;
                        3'b101:  op = OP_DIVU;
                        3'b110:  op = OP_REM;
                        default: op = OP_REMU;
                    endcase
`endif
                end else begin
                    case (func3)
                        3'b000: begin
                            if (base_ok)                                        op = OP_ADD;
                            else if (func7 == FUNC7_ALT)                        op = OP_SUB;
                        end
                        3'b001:  if (func7 == FUNC7_BASE) op = OP_SLL;
                        3'b010:  if (base_ok) op = OP_SLT;
                        3'b011:  if (base_ok) op = OP_SLTU;
                        3'b100:  if (base_ok) op = OP_XOR;
                        3'b110:  if (base_ok) op = OP_OR;
                        3'b111:  if (base_ok) op = OP_AND;
                        default: begin
                            if (func7 == FUNC7_BASE)     op = OP_SRL;
                            else if (func7 == FUNC7_ALT) op = OP_SRA;
                        end
                    endcase
                end
            end
            LTYPE, STYPE, J_ITYPE: op = OP_ADD;
            BTYPE: begin
                case (func3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: op = OP_ILLEGAL;
                endcase
            end
            default: op = OP_ILLEGAL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step.
// Built only when SEQ_ALU_MULDIV_EN is defined; {o_hi,o_lo} is the product, or remainder/quotient.
`ifdef SEQ_ALU_MULDIV_EN
module seq_alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_div,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo,
    output logic            o_last
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] r_hi, r_lo, r_b;
    logic [CW-1:0]   r_cnt;
    logic            r_div;
    logic [XLEN:0]   w_sum, w_trial;

    // Multiply: r_b is the multiplicand, r_lo the multiplier shifted out LSB first.
    // Divide: r_b is the divisor, r_hi the partial remainder, r_lo dividend in / quotient out.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_div ? i_a : i_b;
            r_b   <= i_div ? i_b : i_a;
            r_cnt <= '0;
            r_div <= i_div;
        end else if (i_step) begin
            r_cnt <= r_cnt + 1'b1;
            if (!r_div) begin
                {r_hi, r_lo} <= {w_sum, r_lo[XLEN-1:1]};
            end else if (!w_trial[XLEN]) begin
                r_hi <= w_trial[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], 1'b1};
            end else begin
                r_hi <= {r_hi[XLEN-2:0], r_lo[XLEN-1]};
                r_lo <= {r_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_last = (r_cnt == CW'(XLEN - 1));
endmodule
`endif

// File: rtl/seq_alu.sv
// Sequential RV32I/M execute unit with start/done handshake; base ops finish in one cycle.
// Define SEQ_ALU_MULDIV_EN to build the iterative multiply/divide path.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);

    state_e          r_state, w_state_next;
    logic [XLEN-1:0] r_result, w_result_next, w_base_res;
    logic            r_illegal, w_illegal_next;
    alu_op_e         w_op;
    logic [SHW-1:0]  w_shamt;

    assign w_op    = decode_op(opcode, func3, func7);
    assign w_shamt = op2[SHW-1:0];

    always_comb begin
        w_base_res = '0;
        case (w_op)
            OP_ADD:           w_base_res = op1 + op2;
            OP_SUB:           w_base_res = op1 - op2;
            OP_SLL:           w_base_res = op1 << w_shamt;
            OP_SRL:           w_base_res = op1 >> w_shamt;
            OP_SRA:           w_base_res = $unsigned($signed(op1) >>> w_shamt);
            OP_SLT, OP_BLT:   w_base_res = XLEN'($signed(op1) < $signed(op2));
            OP_SLTU, OP_BLTU: w_base_res = XLEN'(op1 < op2);
            OP_BGE:           w_base_res = XLEN'($signed(op1) >= $signed(op2));
            OP_BGEU:          w_base_res = XLEN'(op1 >= op2);
            OP_BEQ:           w_base_res = XLEN'(op1 == op2);
            OP_BNE:           w_base_res = XLEN'(op1 != op2);
            OP_XOR:           w_base_res = op1 ^ op2;
            OP_OR:            w_base_res = op1 | op2;
            OP_AND:           w_base_res = op1 & op2;
            default:          w_base_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    alu_op_e           r_mop;
    logic              r_neg;
    logic              w_accept, w_is_mul, w_is_div, w_neg_a, w_neg_b, w_div0, w_ovf;
    logic              w_load, w_step, w_last;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_hi, w_lo, w_special_res, w_fix_res;
    logic [2*XLEN-1:0] w_prod;

    assign w_accept = start && (r_state == IDLE);
    assign w_is_mul = w_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    assign w_is_div = w_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign w_neg_a  = (w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && op1[XLEN-1];
    assign w_neg_b  = (w_op inside {OP_MULH, OP_DIV, OP_REM}) && op2[XLEN-1];
    assign w_mag_a  = w_neg_a ? -op1 : op1;
    assign w_mag_b  = w_neg_b ? -op2 : op2;
    assign w_div0   = w_is_div && (op2 == '0);
    assign w_ovf    = (w_op inside {OP_DIV, OP_REM}) && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (&op2);
    assign w_load   = w_accept && (w_is_mul || (w_is_div && !w_div0 && !w_ovf));
    assign w_step   = (r_state == MUL) || (r_state == DIV);

    assign w_special_res = (w_op inside {OP_DIV, OP_DIVU}) ? (w_div0 ? '1 : op1)
                                                           : (w_div0 ? op1 : '0);

    seq_alu_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_step (w_step),
        .i_div  (w_is_div),
        .i_a    (w_mag_a),
        .i_b    (w_mag_b),
        .o_hi   (w_hi),
        .o_lo   (w_lo),
        .o_last (w_last)
    );

    // Remainder takes the dividend's sign; product and quotient take the XOR of both.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mop <= OP_ADD;
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_mop <= w_op;
            r_neg <= (w_op inside {OP_REM, OP_REMU}) ? w_neg_a : (w_neg_a ^ w_neg_b);
        end
    end

    assign w_prod = r_neg ? -{w_hi, w_lo} : {w_hi, w_lo};

    always_comb begin
        w_fix_res = '0;
        case (r_mop)
            OP_MUL:                        w_fix_res = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               w_fix_res = r_neg ? -w_lo : w_lo;
            default:                       w_fix_res = r_neg ? -w_hi : w_hi;
        endcase
    end
`endif

    always_comb begin
        w_state_next   = r_state;
        w_result_next  = r_result;
        w_illegal_next = r_illegal;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next   = DONE;
                    w_result_next  = w_base_res;
                    w_illegal_next = (w_op == OP_ILLEGAL);
`ifdef SEQ_ALU_MULDIV_EN
                    if (w_div0 || w_ovf) begin
                        w_result_next = w_special_res;
                    end else if (w_is_mul || w_is_div) begin
                        w_state_next   = w_is_mul ? MUL : DIV;
                        w_result_next  = r_result;
                        w_illegal_next = r_illegal;
                    end
`endif
                end
            end
`ifdef SEQ_ALU_MULDIV_EN
            MUL, DIV: if (w_last) w_state_next = FIX;
            FIX: begin
                w_state_next   = DONE;
                w_result_next  = w_fix_res;
                w_illegal_next = 1'b0;
            end
`endif
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_result  <= w_result_next;
            r_illegal <= w_illegal_next;
        end
    end

    assign ready   = (r_state == IDLE);
    assign done    = (r_state == DONE);
    assign result  = r_result;
    assign illegal = r_illegal;
endmodule

// File: tb/tb_seq_alu.sv
// Randomized and directed bench for seq_alu against a 64-bit arithmetic reference model.
module tb_seq_alu;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [31:0] op1, op2;
    logic        ready, done, illegal;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_alu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .func3(func3), .func7(func7),
        .op1(op1), .op2(op2), .ready(ready), .done(done), .result(result), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected result, illegal flag and done latency (edges counted from the accepting edge).
    function automatic void ref_model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic ill, output int lat);
        longint sa, sb, p;
        longint unsigned ua, ub, up;
        logic base_f7;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        p  = 0;
        up = 0;
        res = '0; ill = 1'b0; lat = 1;
        base_f7 = (opc == 7'h13) || (f7 == 7'h00);
        if (opc inside {7'h03, 7'h23, 7'h67}) begin
            res = a + b;
        end else if (opc == 7'h63) begin
            case (f3)
                3'd0: res = 32'(a == b);
                3'd1: res = 32'(a != b);
                3'd4: res = 32'(sa < sb);
                3'd5: res = 32'(sa >= sb);
                3'd6: res = 32'(a < b);
                3'd7: res = 32'(a >= b);
                default: ill = 1'b1;
            endcase
        end else if (opc == 7'h33 && f7 == 7'h01) begin
`ifdef SEQ_ALU_MULDIV_EN
            lat = XLEN + 2;
            case (f3)
                3'd0: begin up = ua * ub; res = up[31:0]; end
                3'd1: begin p = sa * sb; res = p[63:32]; end
                3'd2: begin p = sa * longint'(ub); res = p[63:32]; end
                3'd3: begin up = ua * ub; res = up[63:32]; end
                3'd4: begin
                    if (b == 0) begin res = '1; lat = 1; end
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin res = a; lat = 1; end
                    else begin p = sa / sb; res = p[31:0]; end
                end
                3'd5: begin
                    if (b == 0) begin res = '1; lat = 1; end
                    else begin up = ua / ub; res = up[31:0]; end
                end
                3'd6: begin
                    if (b == 0) begin res = a; lat = 1; end
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin res = 0; lat = 1; end
                    else begin p = sa % sb; res = p[31:0]; end
                end
                default: begin
                    if (b == 0) begin res = a; lat = 1; end
                    else begin up = ua % ub; res = up[31:0]; end
                end
            endcase
`else
            ill = 1'b1;
`endif
        end else if (opc == 7'h13 || opc == 7'h33) begin
            case (f3)
                3'd0: if (base_f7) res = a + b; else if (f7 == 7'h20) res = a - b; else ill = 1'b1;
                3'd1: if (f7 == 7'h00) res = a << b[4:0]; else ill = 1'b1;
                3'd2: if (base_f7) res = 32'(sa < sb); else ill = 1'b1;
                3'd3: if (base_f7) res = 32'(a < b); else ill = 1'b1;
                3'd4: if (base_f7) res = a ^ b; else ill = 1'b1;
                3'd6: if (base_f7) res = a | b; else ill = 1'b1;
                3'd7: if (base_f7) res = a & b; else ill = 1'b1;
                default: begin
                    if (f7 == 7'h00) res = a >> b[4:0];
                    else if (f7 == 7'h20) begin p = sa >>> b[4:0]; res = p[31:0]; end
                    else ill = 1'b1;
                end
            endcase
        end else begin
            ill = 1'b1;
        end
    endfunction

    // One transaction: start for one edge, scramble inputs, wait (bounded) for done, check.
    task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input bit poke, output logic [31:0] got, output logic got_ill,
                          output int got_lat);
        logic [31:0] exp_res;
        logic        exp_ill;
        int          exp_lat, n;
        ref_model(opc, f3, f7, a, b, exp_res, exp_ill, exp_lat);
        @(negedge clk);
        check({tag, "/ready_before"}, 64'(ready), 64'd1);
        opcode = opc; func3 = f3; func7 = f7; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op1 = $urandom; op2 = $urandom; opcode = 7'($urandom); func3 = 3'($urandom); func7 = 7'($urandom);
        n = 1;
        while (!done && n < 200) begin
            if (poke && n == 5) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        got = result; got_ill = illegal; got_lat = n;
        check({tag, "/latency"}, 64'(n), 64'(exp_lat));
        check({tag, "/result"}, 64'(result), 64'(exp_res));
        check({tag, "/illegal"}, 64'(illegal), 64'(exp_ill));
        check({tag, "/ready_busy"}, 64'(ready), 64'd0);
        @(posedge clk); #1;
        check({tag, "/done_single"}, 64'(done), 64'd0);
        check({tag, "/ready_after"}, 64'(ready), 64'd1);
        check({tag, "/result_held"}, 64'(result), 64'(exp_res));
        $display("txn %s opc=%h f3=%0d f7=%h a=%h b=%h -> res=%h ill=%0d lat=%0d",
                 tag, opc, f3, f7, a, b, got, got_ill, got_lat);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    logic [6:0]  opc_tab [7] = '{7'h13, 7'h33, 7'h63, 7'h03, 7'h23, 7'h67, 7'h33};
    logic [31:0] got;
    logic        got_ill;
    int          got_lat, pulses;

    initial begin
        rst = 1'b1; start = 1'b0; opcode = '0; func3 = '0; func7 = '0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/ready", 64'(ready), 64'd1);
        check("reset/done", 64'(done), 64'd0);
        check("reset/result", 64'(result), 64'd0);
        check("reset/illegal", 64'(illegal), 64'd0);
        rst = 1'b0;

        run_op("sub", 7'h33, 3'd0, 7'h20, 32'd5, 32'd7, 1'b0, got, got_ill, got_lat);
        check("sub/value", 64'(got), 64'hFFFF_FFFE);
        check("sub/lat", 64'(got_lat), 64'd1);
        run_op("sra", 7'h33, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 1'b0, got, got_ill, got_lat);
        check("sra/value", 64'(got), 64'hF800_0000);
        run_op("slt", 7'h33, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 1'b0, got, got_ill, got_lat);
        check("slt/value", 64'(got), 64'd1);
        run_op("sltu", 7'h33, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 1'b0, got, got_ill, got_lat);
        check("sltu/value", 64'(got), 64'd0);

        run_op("mul", 7'h33, 3'd0, 7'h01, 32'hFFFF_FFFD, 32'd7, 1'b1, got, got_ill, got_lat);
`ifdef SEQ_ALU_MULDIV_EN
        check("mul/value", 64'(got), 64'hFFFF_FFEB);
        check("mul/lat", 64'(got_lat), 64'd34);
        run_op("mulh", 7'h33, 3'd1, 7'h01, 32'hFFFF_FFFD, 32'd7, 1'b0, got, got_ill, got_lat);
        check("mulh/value", 64'(got), 64'hFFFF_FFFF);
        run_op("divu0", 7'h33, 3'd5, 7'h01, 32'd10, 32'd0, 1'b0, got, got_ill, got_lat);
        check("divu0/value", 64'(got), 64'hFFFF_FFFF);
        check("divu0/lat", 64'(got_lat), 64'd1);
        run_op("rem0", 7'h33, 3'd6, 7'h01, 32'd10, 32'd0, 1'b0, got, got_ill, got_lat);
        check("rem0/value", 64'(got), 64'd10);
        run_op("divovf", 7'h33, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, got, got_ill, got_lat);
        check("divovf/value", 64'(got), 64'h8000_0000);
        check("divovf/lat", 64'(got_lat), 64'd1);
        run_op("removf", 7'h33, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, got, got_ill, got_lat);
        check("removf/value", 64'(got), 64'd0);
`else
        check("mul_off/illegal", 64'(got_ill), 64'd1);
        check("mul_off/value", 64'(got), 64'd0);
        check("mul_off/lat", 64'(got_lat), 64'd1);
`endif

        run_op("blt", 7'h63, 3'd4, 7'h00, 32'hFFFF_FFFE, 32'd1, 1'b0, got, got_ill, got_lat);
        check("blt/value", 64'(got), 64'd1);
        run_op("bgeu", 7'h63, 3'd7, 7'h00, 32'hFFFF_FFFE, 32'd1, 1'b0, got, got_ill, got_lat);
        check("bgeu/value", 64'(got), 64'd1);
        run_op("beq", 7'h63, 3'd0, 7'h00, 32'hFFFF_FFFE, 32'd1, 1'b0, got, got_ill, got_lat);
        check("beq/value", 64'(got), 64'd0);
        run_op("b010", 7'h63, 3'd2, 7'h00, 32'hFFFF_FFFE, 32'd1, 1'b0, got, got_ill, got_lat);
        check("b010/illegal", 64'(got_ill), 64'd1);

        // Start held high: re-accepted on every IDLE cycle, so done on every other edge.
        @(negedge clk);
        opcode = 7'h13; func3 = 3'd0; func7 = 7'h00; op1 = 32'd3; op2 = 32'd4; start = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        start = 1'b0;
        check("held/pulses", 64'(pulses), 64'd3);
        check("held/result", 64'(result), 64'd7);
        $display("txn held-start pulses=%0d res=%h", pulses, result);

        // Reset in the middle of a divide aborts it.
        run_op("pre_rst", 7'h33, 3'd0, 7'h00, 32'h1234, 32'd1, 1'b0, got, got_ill, got_lat);
        @(negedge clk);
        opcode = 7'h33; func3 = 3'd4; func7 = 7'h01; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst/ready", 64'(ready), 64'd1);
        check("rst/done", 64'(done), 64'd0);
        check("rst/result", 64'(result), 64'd0);
        check("rst/illegal", 64'(illegal), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("rst/no_done", 64'(pulses), 64'd0);
        $display("txn reset-abort done_after=%0d", pulses);

        for (int i = 0; i < 40; i++) begin
            int k;
            logic [6:0] ropc, rf7;
            k = $urandom_range(0, 7);
            ropc = (k == 7) ? 7'($urandom) : opc_tab[k];
            case ($urandom_range(0, 3))
                0: rf7 = 7'h00;
                1: rf7 = 7'h20;
                2: rf7 = 7'h01;
                default: rf7 = 7'($urandom);
            endcase
            run_op("rand", ropc, 3'($urandom), rf7, pick(), pick(), 1'b0, got, got_ill, got_lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Sequential, parametrised RV32I/RV32M execute unit for the multi-cycle processor. It replaces the purely combinational ALU with a start/done handshake. Base integer ops complete in one cycle; multiply/divide run on an iterative shift-add / restoring-divide datapath. The control FSM issues `start` from its EXECUTE state and waits for `done` before advancing.

## Interface
- `XLEN`, 32: operand/result width; must be a power of two ≥ 8
- `SHW`, $clog2(XLEN): shift-amount width, derived, not overridden
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; accepted only when `ready`=1
- `opcode`  in  7  instruction opcode
- `func3`  in  3  instruction func3
- `func7`  in  7  instruction func7 (full field)
- `op1`, `op2`  in  XLEN  operands, sampled on accepted `start`
- `ready`  out  1  unit idle, can accept `start`
- `done`  out  1  one-cycle pulse, `result`/`illegal` valid
- `result`  out  XLEN  registered result, held until next accepted `start`
- `illegal`  out  1  unsupported opcode/func combination, valid with `done`

## Operation
- Inputs latched on accepted `start`; later input changes have no effect.
- ITYPE 0010011 and RTYPE 0110011 ops:
  - ADD/ADDI
  - SUB (RTYPE, func7[5]=1)
  - SLL, SRL, SRA (op2[SHW-1:0]; func7[5] selects arithmetic)
  - SLT signed, SLTU unsigned, giving 0/1 zero-extended
  - XOR, OR, AND bitwise
- LTYPE 0000011, STYPE 0100011, J_ITYPE 1100111: op1+op2.
- BTYPE 1100011: result = {0…, cond}, where cond follows BEQ/BNE/BLT/BGE/BLTU/BGEU per func3. func3 010/011 is illegal.
- RTYPE with func7=0000001 selects M ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Signed operands are converted to magnitudes, iterated unsigned, then sign-fixed.
- Divide special cases complete without iteration:
  - divide by zero: quotient all-ones, remainder = op1
  - signed overflow (min / −1): quotient = op1, remainder 0
- Any other combination: `illegal`=1, `result`=0.
- FSM states:
  - IDLE: `ready`=1.
    - base op or special case → DONE
    - mul → MUL
    - div → DIV
  - MUL/DIV: one iteration per cycle for XLEN cycles, then → FIX.
  - FIX: sign correction and selection of hi/lo or quotient/remainder → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Arithmetic wraps modulo 2^XLEN. The product accumulator is 2·XLEN bits wide.

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `result`=0, `illegal`=0, iteration counter 0.
- Start accepted at edge T:
  - base op or special divide: `done` high in cycle T+1
  - MUL/DIV: `done` high in cycle T+XLEN+2
- `ready`=0 from T+1 until the cycle after `done`. `start` while not ready is ignored, with no queuing.
- `start` held high continuously is re-accepted in the first IDLE cycle after DONE.
- `rst` asserted mid-operation aborts the operation. No `done` is produced, and all outputs return to reset values on the next edge.
- `result` changes only on the edge entering DONE.

## Configuration
- `SEQ_ALU_MULDIV_EN` defined: M-extension datapath, MUL/DIV/FIX states and the sub-module are compiled in.
- Undefined: func7=0000001 RTYPE ops return `illegal`=1, `result`=0, with `done` at T+1. No multiplier/divider hardware is built.

## Structure
- Package `seq_alu_pkg` holds:
  - opcode constants ITYPE, RTYPE, BTYPE, LTYPE, STYPE, J_ITYPE
  - `alu_op_e` enum (decoded operation)
  - `state_e` enum (IDLE, MUL, DIV, FIX, DONE)
  - M-extension func7 constant
- Sub-module `seq_alu_muldiv` (XLEN parameter): iterative unsigned multiply/divide core with a load/step counter, exposing the 2·XLEN product or quotient/remainder. It is instantiated only under `SEQ_ALU_MULDIV_EN`.

## Test plan
- SUB RTYPE func3 000 func7 0100000, op1=5, op2=7 → `result`=0xFFFFFFFE, `done` at T+1, `illegal`=0.
- SRA op1=0x80000000, op2=4 → 0xF8000000; SLT op1=0xFFFFFFFF, op2=1 → 1; SLTU same operands → 0.
- MUL and MULH, op1=0xFFFFFFFD, op2=7 (macro on, XLEN=32):
  - MUL → 0xFFFFFFEB; MULH → 0xFFFFFFFF
  - `done` at T+34; a `start` pulse at T+5 is ignored
- Divide special cases, each with `done` at T+1:
  - DIVU 10/0 → 0xFFFFFFFF
  - REM 10/0 → 10
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000
  - REM of the same operands → 0
- BTYPE with op1=0xFFFFFFFE, op2=1:
  - BLT → `result`=1
  - BGEU → 1
  - BEQ → 0
  - func3=010 → `illegal`=1
- `rst` asserted at T+10 of a DIV → no `done`; `ready`=1, `result`=0 after the reset edge. With the macro undefined, MUL gives `illegal`=1 at T+1.
